// File: rtl/hash160_digest_tx_if.sv
// Handshake bundle for the Hash160 digest transmitter. The digest input side and the byte output side share one bundle.
// slave = the transmitter itself; master = whatever drives it (upstream hasher plus downstream sink).
interface hash160_digest_tx_if #(
  parameter int DIGEST_W = 160,
  parameter int BYTE_W   = 8
);
  logic                i_valid;
  logic [DIGEST_W-1:0] i_digest;
  logic                o_ready;
  logic                i_flush;
  logic [BYTE_W-1:0]   o_byte;
  logic                o_valid;
  logic                o_last;
  logic                i_ready;

  modport master (
    output i_valid, i_digest, i_flush, i_ready,
    input  o_ready, o_byte, o_valid, o_last
  );

  modport slave (
    input  i_valid, i_digest, i_flush, i_ready,
    output o_ready, o_byte, o_valid, o_last
  );
endinterface

// File: rtl/hash160_digest_tx.sv
// Serializes one Hash160 digest into a valid/ready byte stream, MSB first, with o_last marking the final beat.
// Optional macro HASH160_TX_HEX_ASCII_EN: send each byte as two lowercase ASCII hex characters (2*NB beats).
module hash160_digest_tx #(
  parameter int DIGEST_W = 160,
  parameter int BYTE_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  hash160_digest_tx_if.slave       io_bus
);

  localparam int NB = DIGEST_W / BYTE_W;
`ifdef HASH160_TX_HEX_ASCII_EN
  localparam int NBEATS = 2 * NB;
`else
  localparam int NBEATS = NB;
`endif
  localparam int CNT_W = $clog2(2 * NB);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              r_state;
  logic [DIGEST_W-1:0] r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [BYTE_W-1:0]   r_byte;
  logic                r_valid;
  logic                r_last;

  logic [DIGEST_W-1:0] w_next_shift;
  logic [CNT_W-1:0]    w_next_cnt;
  logic [BYTE_W-1:0]   w_next_byte;
  logic [BYTE_W-1:0]   w_load_byte;

`ifdef HASH160_TX_HEX_ASCII_EN
  logic [BYTE_W-1:0]   w_top;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction
`endif

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    w_next_cnt = r_cnt + 1'b1;
`ifdef HASH160_TX_HEX_ASCII_EN
    // The shift register moves on only after the low-nibble beat of a byte.
    w_next_shift = r_cnt[0] ? (r_shift << BYTE_W) : r_shift;
    w_top        = w_next_shift[DIGEST_W-1 -: BYTE_W];
    w_next_byte  = hex_char(w_next_cnt[0] ? w_top[3:0] : w_top[7:4]);
    w_load_byte  = hex_char(io_bus.i_digest[DIGEST_W-1 -: 4]);
`else
    w_next_shift = r_shift << BYTE_W;
    w_next_byte  = w_next_shift[DIGEST_W-1 -: BYTE_W];
    w_load_byte  = io_bus.i_digest[DIGEST_W-1 -: BYTE_W];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only; the shift register is reset like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (io_bus.i_flush) begin
      // Flush beats any handshake or accept happening at the same edge.
      r_state <= IDLE;
      r_cnt   <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.i_valid) begin
            r_state <= SEND;
            r_shift <= io_bus.i_digest;
            r_cnt   <= '0;
            r_byte  <= w_load_byte;
            r_valid <= 1'b1;
            r_last  <= (LAST_CNT == '0);
          end
        end
        SEND: begin
          if (io_bus.i_ready) begin
            if (r_last) begin
              r_state <= IDLE;
              r_cnt   <= '0;
              r_byte  <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_shift <= w_next_shift;
              r_cnt   <= w_next_cnt;
              r_byte  <= w_next_byte;
              r_last  <= (w_next_cnt == LAST_CNT);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.o_ready = (r_state == IDLE);
  assign io_bus.o_byte  = r_byte;
  assign io_bus.o_valid = r_valid;
  assign io_bus.o_last  = r_last;

endmodule

// File: tb/tb_hash160_digest_tx.sv
// Self-checking bench for hash160_digest_tx: vector table, random digests/backpressure, flush and reset corner cases.
// Build with HASH160_TX_HEX_ASCII_EN defined to exercise the ASCII hex framing.
module tb_hash160_digest_tx;

  localparam int NB = 20;
`ifdef HASH160_TX_HEX_ASCII_EN
  localparam int NBEATS = 2 * NB;
`else
  localparam int NBEATS = NB;
`endif
  localparam int FRAME_BUDGET = 400;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hash160_digest_tx_if #(.DIGEST_W(160), .BYTE_W(8)) bus ();

  hash160_digest_tx #(.DIGEST_W(160), .BYTE_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] got_q[$];

  typedef struct {
    logic [159:0] digest;
    logic [3:0]   pat;
    int           inject;
    logic [7:0]   exp_first;
    logic [7:0]   exp_last;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: beat k of the frame for digest d, straight from the framing rules.
  function automatic logic [7:0] model_beat(input logic [159:0] d, input int k);
    logic [159:0] t;
`ifdef HASH160_TX_HEX_ASCII_EN
    string hx;
    hx = "0123456789abcdef";
    t  = d >> (8 * (NB - 1 - k / 2));
    return (k % 2 == 1) ? hx[t[3:0]] : hx[t[7:4]];
`else
    t = d >> (8 * (NB - 1 - k));
    return t[7:0];
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, bus.o_valid, 1'b0);
    check({tag, "_last"},  bus.o_last,  1'b0);
    check({tag, "_ready"}, bus.o_ready, 1'b1);
  endtask

  // Sends one frame; pat gives the repeating i_ready pattern (bit 0 first) unless rnd is set.
  task automatic run_frame(input logic [159:0] d, input logic [3:0] pat, input bit rnd, input int inject);
    int k = 0;
    int cyc = 0;
    int p = 0;
    bit held = 1'b0;
    logic [7:0] held_b = '0;
    logic held_l = 1'b0;
    logic r;
    got_q.delete();
    check("ready_before_frame", bus.o_ready, 1'b1);
    bus.i_valid  = 1'b1;
    bus.i_digest = d;
    bus.i_ready  = 1'b0;
    tick();
    bus.i_valid = 1'b0;
    check("latency_valid", bus.o_valid, 1'b1);
    while (k < NBEATS && cyc < FRAME_BUDGET) begin
      if (held) begin
        check("hold_byte", bus.o_byte, held_b);
        check("hold_last", bus.o_last, held_l);
      end
      if (bus.o_valid !== 1'b1) begin
        check("valid_in_frame", bus.o_valid, 1'b1);
        break;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : pat[p % 4];
      p++;
      bus.i_ready = r;
      if (k == inject) begin
        bus.i_valid  = 1'b1;
        bus.i_digest = '1;
      end else begin
        bus.i_valid = 1'b0;
      end
      if (r) begin
        check("beat_byte", bus.o_byte, model_beat(d, k));
        check("beat_last", bus.o_last, (k == NBEATS - 1));
        got_q.push_back(bus.o_byte);
        k++;
        held = 1'b0;
      end else begin
        held   = 1'b1;
        held_b = bus.o_byte;
        held_l = bus.o_last;
      end
      tick();
      cyc++;
    end
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b0;
    check("beats_in_frame", k, NBEATS);
    check_idle("after_frame");
    if (inject >= 0) begin
      tick();
      check("no_second_frame", bus.o_valid, 1'b0);
    end
  endtask

  // Accepts d with i_ready=1 and stops with beat `beat` on the output.
  task automatic start_to_beat(input logic [159:0] d, input int beat);
    bus.i_valid  = 1'b1;
    bus.i_digest = d;
    tick();
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    for (int i = 0; i < beat; i++) tick();
    bus.i_ready = 1'b0;
    check("mid_frame_byte", bus.o_byte, model_beat(d, beat));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic [159:0] d1, d2;

    vecs[0] = '{160'h0102030405060708090a0b0c0d0e0f1011121314, 4'b1111, -1, 8'h00, 8'h00};
    vecs[1] = '{160'h0102030405060708090a0b0c0d0e0f1011121314, 4'b1001, -1, 8'h00, 8'h00};
    vecs[2] = '{{8'hab, 144'h0, 8'h01},                          4'b0101,  7, 8'h00, 8'h00};
    vecs[3] = '{{8'h80, 144'h0, 8'hff},                          4'b1110, -1, 8'h00, 8'h00};
`ifdef HASH160_TX_HEX_ASCII_EN
    vecs[0].exp_first = 8'h30; vecs[0].exp_last = 8'h34;
    vecs[1].exp_first = 8'h30; vecs[1].exp_last = 8'h34;
    vecs[2].exp_first = 8'h61; vecs[2].exp_last = 8'h31;
    vecs[3].exp_first = 8'h38; vecs[3].exp_last = 8'h66;
`else
    vecs[0].exp_first = 8'h01; vecs[0].exp_last = 8'h14;
    vecs[1].exp_first = 8'h01; vecs[1].exp_last = 8'h14;
    vecs[2].exp_first = 8'hab; vecs[2].exp_last = 8'h01;
    vecs[3].exp_first = 8'h80; vecs[3].exp_last = 8'hff;
`endif

    bus.i_valid  = 1'b0;
    bus.i_digest = '0;
    bus.i_flush  = 1'b0;
    bus.i_ready  = 1'b0;
    rst_n        = 1'b0;

    // Reset asserted, then released.
    tick();
    tick();
    check_idle("in_reset");
    check("in_reset_byte", bus.o_byte, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("after_reset");
    check("after_reset_byte", bus.o_byte, 8'h00);

    // Vector table.
    foreach (vecs[i]) begin
      run_frame(vecs[i].digest, vecs[i].pat, 1'b0, vecs[i].inject);
      check("vec_size", got_q.size(), NBEATS);
      check("vec_first", got_q[0], vecs[i].exp_first);
      check("vec_last", got_q[NBEATS-1], vecs[i].exp_last);
    end

`ifdef HASH160_TX_HEX_ASCII_EN
    // ab00..0001 as ASCII hex: opening and closing beats.
    run_frame({8'hab, 144'h0, 8'h01}, 4'b1111, 1'b0, -1);
    check("hex_beat0", got_q[0], 8'h61);
    check("hex_beat1", got_q[1], 8'h62);
    check("hex_beat2", got_q[2], 8'h30);
    check("hex_beat3", got_q[3], 8'h30);
    check("hex_beat38", got_q[38], 8'h30);
    check("hex_beat39", got_q[39], 8'h31);
`endif

    // Random digests under random backpressure, back to back.
    for (int n = 0; n < 8; n++) begin
      d1 = {$urandom, $urandom, $urandom, $urandom, $urandom};
      run_frame(d1, 4'b0000, 1'b1, (n % 3 == 0) ? int'($urandom_range(0, NBEATS - 1)) : -1);
    end

    // Flush at beat 5 together with a handshake and an upstream valid.
    d1 = 160'h0102030405060708090a0b0c0d0e0f1011121314;
    d2 = 160'hc0ffee00112233445566778899aabbccddeeff42;
    start_to_beat(d1, 5);
    bus.i_flush = 1'b1;
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b0;
    check_idle("after_flush");
    run_frame(d2, 4'b1111, 1'b0, -1);
    check("post_flush_beat0", got_q[0], model_beat(d2, 0));

    // Flush in IDLE blocks a simultaneous accept.
    bus.i_flush  = 1'b1;
    bus.i_valid  = 1'b1;
    bus.i_digest = d2;
    tick();
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    check_idle("idle_flush");

    // Asynchronous reset at beat 10.
    start_to_beat(d1, 10);
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    check("mid_reset_byte", bus.o_byte, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("after_mid_reset");
    check("after_mid_reset_byte", bus.o_byte, 8'h00);
    run_frame(d2, 4'b1001, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
